// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequential front end for an 8-row memory array.
//
// Accepts single-word read/write requests on a valid/ready handshake. It drives
// the 3-bit row address (adr0..adr2) to the row decoder and generates registered
// din/wr_en/rd_en strobes. Read data from the array is captured and returned on
// a one-cycle response pulse. After reset it can optionally sweep all rows to
// INIT_VALUE before accepting traffic.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_adr, req_wdata    request fields, sampled on handshake
//   rsp_valid, rsp_rdata          one-cycle completion pulse and read data
//   init_done                     high once the init sweep has finished
//   adr0, adr1, adr2              row address to the decoder (LSB..MSB)
//   wr_en, rd_en, din             array strobes and write data
//   dout                          array read data, valid in the rd_en cycle
//
// Every output is a flop. The next-state logic computes what the bus shows in
// the following cycle, so state_q always names the cycle currently on the bus.
module mem_access_ctrl #(
    parameter int unsigned       DATA_W        = 8,
    parameter int unsigned       SETUP_CYCLES  = 1,
    parameter bit                INIT_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_adr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              adr0,
    output logic              adr1,
    output logic              adr2,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
);

    typedef enum logic [2:0] {StInit, StIdle, StSetup, StStrobe, StResp} state_e;

    localparam state_e     ResetState = INIT_ON_RESET ? StInit : StIdle;
    localparam logic [2:0] SetupLast  = 3'(SETUP_CYCLES);
    localparam logic [2:0] SetupLoad  = 3'(SETUP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        row_q, row_d;     // init sweep row
    logic [2:0]        cnt_q, cnt_d;     // init: setup cycles shown; setup: cycles left
    logic              we_q, we_d;
    logic [2:0]        adr_q, adr_d;
    logic [DATA_W-1:0] din_d, rsp_rdata_d;
    logic              wr_en_d, rd_en_d, rsp_valid_d, req_ready_d, init_done_d;

    assign adr0 = adr_q[0];
    assign adr1 = adr_q[1];
    assign adr2 = adr_q[2];

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        adr_d       = adr_q;
        din_d       = din;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        req_ready_d = 1'b0;
        init_done_d = init_done;

        unique case (state_q)
            StInit: begin
                if (wr_en) begin
                    // The strobe of row_q is on the bus now.
                    if (row_q == 3'd7) begin
                        state_d     = StIdle;
                        init_done_d = 1'b1;
                        req_ready_d = 1'b1;
                    end else begin
                        row_d = row_q + 3'd1;
                        adr_d = row_q + 3'd1;
                        din_d = INIT_VALUE;
                        cnt_d = 3'd1;
                    end
                end else if (cnt_q < SetupLast) begin
                    adr_d = row_q;
                    din_d = INIT_VALUE;
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    wr_en_d = 1'b1;
                end
            end
            StIdle: begin
                init_done_d = 1'b1;
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    adr_d   = req_adr;
                    cnt_d   = SetupLoad;
                    state_d = StSetup;
                    if (req_we) begin
                        din_d = req_wdata;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_q == 3'd0) begin
                    state_d = StStrobe;
                    wr_en_d = we_q;
                    rd_en_d = !we_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StStrobe: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                if (!we_q) begin
                    rsp_rdata_d = dout;
                end
            end
            StResp: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ResetState;
            row_q     <= 3'd0;
            cnt_q     <= 3'd0;
            we_q      <= 1'b0;
            adr_q     <= 3'd0;
            din       <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            din       <= din_d;
            wr_en     <= wr_en_d;
            rd_en     <= rd_en_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            req_ready <= req_ready_d;
            init_done <= init_done_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: default instance (init sweep, 1 setup cycle) with a
// behavioural 8x8 array attached, plus a second instance with 3 setup cycles and
// no init sweep. Responses of the main instance are checked against a queue of
// expected results pushed at handshake time.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [2:0] req_adr;
    logic [7:0] req_wdata, rsp_rdata, din, dout;
    logic       rsp_valid, init_done, adr0, adr1, adr2, wr_en, rd_en;

    logic       b_req_valid, b_req_ready, b_req_we;
    logic [2:0] b_req_adr;
    logic [7:0] b_req_wdata, b_rsp_rdata, b_din, b_dout;
    logic       b_rsp_valid, b_init_done, b_adr0, b_adr1, b_adr2, b_wr_en, b_rd_en;

    assign b_dout = 8'h3C;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .adr0(adr0), .adr1(adr1), .adr2(adr2), .wr_en(wr_en), .rd_en(rd_en),
        .din(din), .dout(dout)
    );

    mem_access_ctrl #(.SETUP_CYCLES(3), .INIT_ON_RESET(1'b0)) dut3 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_adr(b_req_adr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .init_done(b_init_done),
        .adr0(b_adr0), .adr1(b_adr1), .adr2(b_adr2), .wr_en(b_wr_en), .rd_en(b_rd_en),
        .din(b_din), .dout(b_dout)
    );

    // Behavioural array: combinational read, write on the strobe edge.
    logic [7:0] arr [8];
    assign dout = arr[{adr2, adr1, adr0}];
    always @(posedge clk) if (wr_en) arr[{adr2, adr1, adr0}] <= din;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       sb [$];
    exp_t       mon_e;
    logic [7:0] ref_mem [8];
    logic [7:0] last_rd;

    always @(negedge clk) begin
        check("rw_overlap", 32'(wr_en & rd_en), 32'd0);
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.data));
                check("rsp_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    // Leaves req_valid high; the caller drops it when no follow-on request.
    task automatic do_req(input logic we, input logic [2:0] adr, input logic [7:0] wd,
                          output int hs);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        hs = -1;
        @(negedge clk);
        req_we    = we;
        req_adr   = adr;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("hs_timeout", 32'd0, 32'd1);
            return;
        end
        hs = cyc;
        if (we) begin
            ref_mem[adr] = wd;
            e.data = last_rd;
        end else begin
            e.data  = ref_mem[adr];
            last_rd = ref_mem[adr];
        end
        e.at = hs + 3;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check();
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("init_wr_en", 32'(wr_en), 32'(i % 2 == 0));
            check("init_adr", 32'({adr2, adr1, adr0}), 32'((i - 1) / 2));
            check("init_din", 32'(din), 32'd0);
            check("init_ready_lo", 32'(req_ready), 32'd0);
            check("init_done_lo", 32'(init_done), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        check("init_done_hi", 32'(init_done), 32'd1);
        check("init_ready_hi", 32'(req_ready), 32'd1);
        check("init_wr_after", 32'(wr_en), 32'd0);
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic dut3_test();
        @(negedge clk);
        check("s3_ready_rst", 32'(b_req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("s3_ready_first", 32'(b_req_ready), 32'd1);
        check("s3_done_first", 32'(b_init_done), 32'd1);
        b_req_we    = 1'b0;
        b_req_adr   = 3'd6;
        b_req_wdata = 8'h00;
        b_req_valid = 1'b1;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("s3_adr", 32'({b_adr2, b_adr1, b_adr0}), 32'd6);
            check("s3_rd_en", 32'(b_rd_en), 32'(k == 4));
            check("s3_wr_en", 32'(b_wr_en), 32'd0);
            check("s3_rsp_valid", 32'(b_rsp_valid), 32'(k == 5));
            if (k == 5) check("s3_rsp_rdata", 32'(b_rsp_rdata), 32'h3C);
        end
    endtask

    int h1, h2;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_adr = 3'd0; req_wdata = 8'h00;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_adr = 3'd0; b_req_wdata = 8'h00;
        last_rd = 8'h00;
        for (int i = 0; i < 8; i++) begin
            arr[i]     = 8'h5A;
            ref_mem[i] = 8'h00;
        end

        @(negedge clk);
        check("rst_adr", 32'({adr2, adr1, adr0}), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_din", 32'(din), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        fork
            sweep_check();
            dut3_test();
        join

        // Write 5 <- A5: address/data held for setup + strobe, wr_en only in strobe.
        do_req(1'b1, 3'b101, 8'hA5, h1);
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("wr_adr", 32'({adr2, adr1, adr0}), 32'h5);
            check("wr_din", 32'(din), 32'hA5);
            check("wr_en_pulse", 32'(wr_en), 32'(k == 2));
            check("wr_rd_en", 32'(rd_en), 32'd0);
        end

        // Read 5 back.
        do_req(1'b0, 3'b101, 8'h00, h1);
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("rd_en_pulse", 32'(rd_en), 32'(k == 2));
            check("rd_wr_en", 32'(wr_en), 32'd0);
        end

        // Unwritten row reads the swept value.
        do_req(1'b0, 3'd2, 8'h00, h1);
        req_valid = 1'b0;

        // Back-to-back with req_valid held high.
        do_req(1'b1, 3'd7, 8'hC3, h1);
        do_req(1'b0, 3'd0, 8'h00, h2);
        req_valid = 1'b0;
        check("b2b_gap", 32'(h2 - h1), 32'd4);
        do_req(1'b0, 3'd7, 8'h00, h1);
        req_valid = 1'b0;

        // Reset in the strobe cycle of a write aborts it without a clock edge.
        repeat (5) @(negedge clk);
        do_req(1'b1, 3'd3, 8'h77, h1);
        req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 check("abort_wr_before", 32'(wr_en), 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_wr_after", 32'(wr_en), 32'd0);
        check("abort_rsp", 32'(rsp_valid), 32'd0);
        last_rd = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        sweep_check();

        do_req(1'b0, 3'd3, 8'h00, h1);
        do_req(1'b0, 3'd5, 8'h00, h1);
        do_req(1'b1, 3'd0, 8'h3F, h1);
        do_req(1'b0, 3'd0, 8'h00, h1);
        req_valid = 1'b0;

        for (int t = 0; t < 20; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
